// File: rtl/sata_dma_pkg.sv
// Shared types and widths for the SATA DMA data mover.
package sata_dma_pkg;

  localparam int BEATS_W = 5;
  localparam int WORDS_W = 14;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_CMD  = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd4,
    ST_HOLD = 3'd5
  } dma_state_e;

endpackage

// File: rtl/sata_dma_burst_calc.sv
// Registered burst sizing: min(words left, max burst, words to the next address boundary).
module sata_dma_burst_calc
  import sata_dma_pkg::*;
#(
  parameter int C_MAX_BURST     = 16,
  parameter int C_BOUNDARY_LOG2 = 12
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       load,
  input  logic [C_BOUNDARY_LOG2-3:0] cur_word_lo,
  input  logic [WORDS_W-1:0]         words_rem,
  output logic [BEATS_W-1:0]         beats
);

  localparam int BW = C_BOUNDARY_LOG2 - 1;

  logic [BW-1:0]      bound_words;
  logic [BEATS_W-1:0] lim;
  logic [BEATS_W-1:0] beats_d;
  logic [BEATS_W-1:0] beats_q;

  // Word offset inside the boundary window is subtracted from the window size in words.
  assign bound_words = {1'b1, {(BW-1){1'b0}}} - {1'b0, cur_word_lo};

  always_comb begin
    lim = words_rem[BEATS_W-1:0];
    if (words_rem > WORDS_W'(C_MAX_BURST)) begin
      lim = BEATS_W'(C_MAX_BURST);
    end
    beats_d = lim;
    if (bound_words < BW'(lim)) begin
      beats_d = bound_words[BEATS_W-1:0];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      beats_q <= '0;
    end else if (load) begin
      beats_q <= beats_d;
    end
  end

  assign beats = beats_q;

endmodule

// File: rtl/sata_dma_mover.sv
// SATA DMA data mover: splits a latched descriptor into bounded memory bursts and
// streams 32-bit words between the link FIFOs and memory, then pulses dma_ack.
//
// state | meaning
// IDLE  | waiting for dma_req; latches descriptor and clears error
// CALC  | burst size registered from current address and words left
// CMD   | burst command held on the memory port until accepted
// DATA  | beats counted down on valid&ready; mem_err aborts
// DONE  | one-cycle dma_ack
// HOLD  | one dead cycle while the producer drops dma_req
module sata_dma_mover
  import sata_dma_pkg::*;
#(
  parameter int C_MAX_BURST     = 16,
  parameter int C_BOUNDARY_LOG2 = 12
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] dma_address,
  input  logic [15:0] dma_length,
  input  logic        dma_wrt,
  input  logic        dma_req,
  output logic        dma_ack,
  output logic        dma_err,
  output logic [31:0] mem_addr,
  output logic [4:0]  mem_beats,
  output logic        mem_rnw,
  output logic        mem_cmd_valid,
  input  logic        mem_cmd_ready,
  output logic [31:0] mem_wdata,
  output logic        mem_wvalid,
  input  logic        mem_wready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        mem_rready,
  input  logic        mem_err,
  input  logic [31:0] rxd_data,
  input  logic        rxd_valid,
  output logic        rxd_ready,
  output logic [31:0] txd_data,
  output logic        txd_valid,
  input  logic        txd_ready
);

  dma_state_e         state_d, state_q;
  logic [31:0]        cur_addr_d, cur_addr_q;
  logic [WORDS_W-1:0] words_rem_d, words_rem_q;
  logic               wrt_d, wrt_q;
  logic [BEATS_W-1:0] beat_cnt_d, beat_cnt_q;
  logic               err_d, err_q;
  logic [BEATS_W-1:0] beats;

  logic in_cmd;
  logic data_en;
  logic wr_en;
  logic rd_en;
  logic beat_fire;
  logic unused_lsbs;

  assign unused_lsbs = ^{dma_address[1:0], dma_length[1:0]};

  sata_dma_burst_calc #(
    .C_MAX_BURST    (C_MAX_BURST),
    .C_BOUNDARY_LOG2(C_BOUNDARY_LOG2)
  ) u_burst_calc (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .load       (state_q == ST_CALC),
    .cur_word_lo(cur_addr_q[C_BOUNDARY_LOG2-1:2]),
    .words_rem  (words_rem_q),
    .beats      (beats)
  );

  // A bus error closes the data window in the same cycle so no further word moves.
  assign in_cmd    = (state_q == ST_CMD);
  assign data_en   = (state_q == ST_DATA) && !mem_err;
  assign wr_en     = data_en && wrt_q;
  assign rd_en     = data_en && !wrt_q;
  assign beat_fire = wr_en ? (rxd_valid && mem_wready) : (rd_en && mem_rvalid && txd_ready);

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    words_rem_d = words_rem_q;
    wrt_d       = wrt_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (dma_req) begin
          cur_addr_d  = {dma_address[31:2], 2'b00};
          words_rem_d = dma_length[15:2];
          wrt_d       = dma_wrt;
          err_d       = 1'b0;
          state_d     = (dma_length[15:2] == '0) ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: state_d = ST_CMD;
      ST_CMD: begin
        if (mem_cmd_ready) begin
          beat_cnt_d  = beats;
          cur_addr_d  = cur_addr_q + {{(32-BEATS_W-2){1'b0}}, beats, 2'b00};
          words_rem_d = words_rem_q - {{(WORDS_W-BEATS_W){1'b0}}, beats};
          state_d     = ST_DATA;
        end
      end
      ST_DATA: begin
        if (mem_err) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (beat_fire) begin
          beat_cnt_d = beat_cnt_q - 1'b1;
          if (beat_cnt_q == BEATS_W'(1)) begin
            state_d = (words_rem_q != '0) ? ST_CALC : ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_HOLD;
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      words_rem_q <= '0;
      wrt_q       <= 1'b0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      words_rem_q <= words_rem_d;
      wrt_q       <= wrt_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
    end
  end

  assign dma_ack       = (state_q == ST_DONE);
  assign dma_err       = err_q;
  assign mem_cmd_valid = in_cmd;
  assign mem_addr      = in_cmd ? cur_addr_q : '0;
  assign mem_beats     = in_cmd ? beats : '0;
  assign mem_rnw       = in_cmd && !wrt_q;

  assign mem_wvalid = wr_en && rxd_valid;
  assign rxd_ready  = wr_en && mem_wready;
  assign mem_wdata  = wr_en ? rxd_data : '0;

  assign txd_valid  = rd_en && mem_rvalid;
  assign mem_rready = rd_en && txd_ready;
  assign txd_data   = rd_en ? mem_rdata : '0;

endmodule

// File: tb/tb_sata_dma_mover.sv
// Self-checking bench for sata_dma_mover: table-driven transfers against a burst/data
// scoreboard, plus hand-written zero-length and mid-transfer reset sequences.
module tb_sata_dma_mover;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [31:0] dma_address = '0;
  logic [15:0] dma_length = '0;
  logic        dma_wrt = 1'b0;
  logic        dma_req = 1'b0;
  logic        dma_ack, dma_err;
  logic [31:0] mem_addr;
  logic [4:0]  mem_beats;
  logic        mem_rnw, mem_cmd_valid;
  logic        mem_cmd_ready = 1'b0;
  logic [31:0] mem_wdata;
  logic        mem_wvalid;
  logic        mem_wready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic        mem_rready;
  logic        mem_err = 1'b0;
  logic [31:0] rxd_data = '0;
  logic        rxd_valid = 1'b0;
  logic        rxd_ready;
  logic [31:0] txd_data;
  logic        txd_valid;
  logic        txd_ready = 1'b0;

  always #5 sys_clk = ~sys_clk;

  sata_dma_mover #(.C_MAX_BURST(16), .C_BOUNDARY_LOG2(12)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .dma_address(dma_address), .dma_length(dma_length), .dma_wrt(dma_wrt), .dma_req(dma_req),
    .dma_ack(dma_ack), .dma_err(dma_err),
    .mem_addr(mem_addr), .mem_beats(mem_beats), .mem_rnw(mem_rnw),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_wdata(mem_wdata), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_err(mem_err),
    .rxd_data(rxd_data), .rxd_valid(rxd_valid), .rxd_ready(rxd_ready),
    .txd_data(txd_data), .txd_valid(txd_valid), .txd_ready(txd_ready)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [4:0]  beats;
    logic        rnw;
  } burst_t;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] len;
    logic        wrt;
    bit          stall;
    int          err_at;
    int          exp_bursts;
    int          exp_first_beats;
    logic        exp_err;
  } vec_t;

  burst_t      exp_burst_q[$];
  logic [31:0] exp_data_q[$];

  int n_pass = 0;
  int n_total = 0;

  bit          stall_en, ack_seen, err_done, prev_stall;
  int          err_at, rd_out, wr_out, src_idx, src_total, rd_idx;
  int          pops, pushes, memwr, memrd, acks, cmds;
  logic [31:0] data_base, prev_addr;
  logic [4:0]  prev_beats, first_beats;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic any_out();
    return |{dma_ack, dma_err, mem_addr, mem_beats, mem_rnw, mem_cmd_valid, mem_wdata,
             mem_wvalid, mem_rready, rxd_ready, txd_data, txd_valid};
  endfunction

  function automatic void reset_model();
    exp_burst_q.delete();
    exp_data_q.delete();
    ack_seen = 0; err_done = 0; prev_stall = 0; stall_en = 0; err_at = -1;
    rd_out = 0; wr_out = 0; src_idx = 0; src_total = 0; rd_idx = 0;
    pops = 0; pushes = 0; memwr = 0; memrd = 0; acks = 0; cmds = 0; first_beats = '0;
  endfunction

  // Reference splitting: words left, 16-beat cap, 4 KiB boundary.
  function automatic void plan(input logic [31:0] addr, input int words, input logic rnw);
    logic [31:0] a;
    int w, b, bw;
    burst_t bt;
    a = {addr[31:2], 2'b00};
    w = words;
    while (w > 0) begin
      bw = (4096 - int'(a[11:0])) / 4;
      b = w;
      if (b > 16) b = 16;
      if (b > bw) b = bw;
      bt.addr = a; bt.beats = 5'(b); bt.rnw = rnw;
      exp_burst_q.push_back(bt);
      a = a + 32'(b * 4);
      w = w - b;
    end
  endfunction

  task automatic tick();
    burst_t bt;
    @(negedge sys_clk);
    if (ack_seen) dma_req = 1'b0;
    else if (cmds > 0 && dma_req) begin
      dma_address = $urandom;
      dma_length  = 16'($urandom);
      dma_wrt     = 1'($urandom_range(0, 1));
    end
    mem_cmd_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    txd_ready     = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    mem_wready    = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    mem_rvalid    = (rd_out > 0) && (stall_en ? 1'($urandom_range(0, 1)) : 1'b1);
    mem_rdata     = data_base + 32'(rd_idx);
    rxd_valid     = (src_idx < src_total) && (stall_en ? 1'($urandom_range(0, 1)) : 1'b1);
    rxd_data      = data_base + 32'(src_idx);
    mem_err       = 1'b0;
    if (err_at >= 0 && pops == err_at && !err_done) begin
      mem_err  = 1'b1;
      err_done = 1;
    end
    #1;
    if (prev_stall) begin
      check("cmd_hold_valid", 32'(mem_cmd_valid), 32'd1);
      check("cmd_hold_addr", mem_addr, prev_addr);
      check("cmd_hold_beats", 32'(mem_beats), 32'(prev_beats));
    end
    prev_stall = mem_cmd_valid && !mem_cmd_ready;
    prev_addr  = mem_addr;
    prev_beats = mem_beats;
    if (mem_cmd_valid && mem_cmd_ready) begin
      if (cmds == 0) first_beats = mem_beats;
      cmds++;
      if (exp_burst_q.size() == 0) check("cmd_unexpected", 32'd1, 32'd0);
      else begin
        bt = exp_burst_q.pop_front();
        check("cmd_addr", mem_addr, bt.addr);
        check("cmd_beats", 32'(mem_beats), 32'(bt.beats));
        check("cmd_rnw", 32'(mem_rnw), 32'(bt.rnw));
        if (bt.rnw) rd_out += int'(bt.beats);
        else wr_out += int'(bt.beats);
      end
    end
    if (txd_valid && txd_ready) begin
      if (exp_data_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
      else check("rd_data", txd_data, exp_data_q.pop_front());
      rd_out--; rd_idx++; pushes++;
    end
    if (mem_rvalid && mem_rready) memrd++;
    if (mem_wvalid && mem_wready) begin
      check("wr_in_burst", 32'(wr_out > 0), 32'd1);
      if (exp_data_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
      else check("wr_data", mem_wdata, exp_data_q.pop_front());
      wr_out--; memwr++;
    end
    if (rxd_valid && rxd_ready) begin
      src_idx++; pops++;
    end
    if (dma_ack) begin
      acks++; ack_seen = 1;
    end
  endtask

  task automatic start_xfer(input logic [31:0] addr, input logic [15:0] len, input logic wrt);
    int nwords;
    reset_model();
    data_base = $urandom;
    nwords = int'(len[15:2]);
    plan(addr, nwords, !wrt);
    for (int i = 0; i < nwords; i++) exp_data_q.push_back(data_base + 32'(i));
    src_total = wrt ? nwords : 0;
    @(negedge sys_clk);
    dma_address = addr; dma_length = len; dma_wrt = wrt; dma_req = 1'b1;
  endtask

  task automatic run_xfer(input string tag, input vec_t v);
    int exp_words;
    start_xfer(v.addr, v.len, v.wrt);
    stall_en = v.stall;
    err_at = v.err_at;
    exp_words = (v.err_at >= 0) ? v.err_at : int'(v.len[15:2]);
    for (int c = 0; c < 3000 && !ack_seen; c++) tick();
    check({tag, "_ack_seen"}, 32'(ack_seen), 32'd1);
    repeat (3) tick();
    check({tag, "_ack_count"}, 32'(acks), 32'd1);
    check({tag, "_bursts"}, 32'(cmds), 32'(v.exp_bursts));
    check({tag, "_first_beats"}, 32'(first_beats), 32'(v.exp_first_beats));
    check({tag, "_words"}, 32'(v.wrt ? pops : pushes), 32'(exp_words));
    check({tag, "_mem_side_beats"}, 32'(v.wrt ? memwr : memrd), 32'(exp_words));
    check({tag, "_dma_err"}, 32'(dma_err), 32'(v.exp_err));
    check({tag, "_cmds_left"}, 32'(exp_burst_q.size()), 32'(v.exp_bursts - cmds));
    stall_en = 0;
  endtask

  vec_t vecs[5];
  int   lat;

  initial begin
    vecs[0] = '{addr: 32'h0000_1000, len: 16'd64,  wrt: 1'b1, stall: 1'b0, err_at: -1,
                exp_bursts: 1, exp_first_beats: 16, exp_err: 1'b0};
    vecs[1] = '{addr: 32'h0000_0FF8, len: 16'd40,  wrt: 1'b0, stall: 1'b0, err_at: -1,
                exp_bursts: 2, exp_first_beats: 2, exp_err: 1'b0};
    vecs[2] = '{addr: 32'h0000_2000, len: 16'd100, wrt: 1'b0, stall: 1'b1, err_at: -1,
                exp_bursts: 2, exp_first_beats: 16, exp_err: 1'b0};
    vecs[3] = '{addr: 32'h0000_3000, len: 16'd64,  wrt: 1'b1, stall: 1'b0, err_at: 5,
                exp_bursts: 1, exp_first_beats: 16, exp_err: 1'b1};
    vecs[4] = '{addr: 32'h0000_0FFE, len: 16'd26,  wrt: 1'b1, stall: 1'b1, err_at: -1,
                exp_bursts: 2, exp_first_beats: 1, exp_err: 1'b0};

    reset_model();
    data_base = '0;
    #1;
    check("reset_outputs_zero", 32'(any_out()), 32'd0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    #1;
    check("post_reset_outputs_zero", 32'(any_out()), 32'd0);

    for (int i = 0; i < 5; i++) run_xfer($sformatf("vec%0d", i), vecs[i]);

    // Zero-length: dma_length=3 carries no whole words.
    start_xfer(32'h0000_5000, 16'd3, 1'b1);
    lat = 0;
    for (int c = 0; c < 4 && !ack_seen; c++) begin
      tick();
      lat++;
    end
    check("len0_ack_seen", 32'(ack_seen), 32'd1);
    check("len0_ack_in_time", 32'(lat <= 2), 32'd1);
    repeat (3) tick();
    check("len0_ack_count", 32'(acks), 32'd1);
    check("len0_no_cmd", 32'(cmds), 32'd0);

    // Reset in the middle of a write burst.
    start_xfer(32'h0000_4000, 16'd64, 1'b1);
    for (int c = 0; c < 200 && pops < 3; c++) tick();
    check("rst_mid_reached_data", 32'(pops >= 3), 32'd1);
    sys_rst_n = 1'b0;
    #1;
    check("rst_mid_outputs_zero", 32'(any_out()), 32'd0);
    reset_model();
    dma_req = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (5) tick();
    check("rst_mid_no_ack", 32'(acks), 32'd0);
    check("rst_mid_no_cmd", 32'(cmds), 32'd0);
    run_xfer("after_rst", '{addr: 32'h0000_4000, len: 16'd64, wrt: 1'b1, stall: 1'b0,
                            err_at: -1, exp_bursts: 1, exp_first_beats: 16, exp_err: 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sata_dma_mover.md
Name: sata_dma_mover

Overview:
- Data mover for the SATA port. It consumes the DMA descriptor that the DCR register block holds: address, byte length, direction and a level-held request.
- It splits the transfer into bounded memory bursts on the memory command port.
- It moves 32-bit words between the link-side FIFOs and memory, then returns a one-cycle dma_ack, which clears the request and raises the DMA interrupt upstream.

Parameters:
- C_MAX_BURST, 16, maximum beats (32-bit words) per memory burst; power of two, 1..16.
- C_BOUNDARY_LOG2, 12, no burst crosses a 2**C_BOUNDARY_LOG2-byte address boundary.

Ports:
- sys_clk  in  1  single clock for the whole block.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- dma_address  in  32  start byte address; bits [1:0] are ignored (treated as 0).
- dma_length  in  16  transfer length in bytes; bits [1:0] are ignored.
- dma_wrt  in  1  1 = FIFO-to-memory (memory write); 0 = memory-to-FIFO (memory read).
- dma_req  in  1  level request, held by the producer until dma_ack is seen.
- dma_ack  out  1  one-cycle completion pulse.
- dma_err  out  1  sticky error flag; cleared on acceptance of the next request.
- mem_addr  out  32  burst start byte address.
- mem_beats  out  5  burst length in words, 1..C_MAX_BURST.
- mem_rnw  out  1  1 = read burst.
- mem_cmd_valid  out  1  command valid.
- mem_cmd_ready  in  1  command accepted.
- mem_wdata  out  32  write data, passed through from rxd_data.
- mem_wvalid  out  1  write beat valid.
- mem_wready  in  1  memory accepts the write beat.
- mem_rdata  in  32  read data.
- mem_rvalid  in  1  read beat valid.
- mem_rready  out  1  read beat accepted.
- mem_err  in  1  memory reports a bus error; sampled in DATA state.
- rxd_data  in  32  FIFO word going to memory.
- rxd_valid  in  1  FIFO word available.
- rxd_ready  out  1  FIFO pop.
- txd_data  out  32  word going to the FIFO, passed through from mem_rdata.
- txd_valid  out  1  push.
- txd_ready  in  1  FIFO not full.

Behaviour:
- Reset (async assert, sync release): state = IDLE. All outputs are 0, including mem_addr, mem_beats, dma_ack and dma_err.
- **Word arithmetic:**
  - words_rem is 14 bits, loaded from dma_length[15:2].
  - cur_addr is 32 bits, loaded from {dma_address[31:2], 2'b00}.
  - bound_words = (2**C_BOUNDARY_LOG2 - cur_addr[C_BOUNDARY_LOG2-1:0]) >> 2.
  - beats = min(words_rem, C_MAX_BURST, bound_words).
  - After each burst: cur_addr += beats*4, wrapping modulo 2**32; words_rem -= beats.
- **FSM:**
  - IDLE: on dma_req=1, latch the descriptor and clear dma_err. If the word count is 0, go to DONE; otherwise go to CALC.
  - CALC: beats is computed and registered. Takes 1 cycle, then go to CMD.
  - CMD: drive mem_cmd_valid=1 with mem_addr=cur_addr, mem_beats=beats, mem_rnw=~dma_wrt. Hold all of them stable until mem_cmd_ready; then load beat_cnt=beats and go to DATA.
  - DATA, write direction: mem_wvalid=rxd_valid, rxd_ready=mem_wready, mem_wdata=rxd_data, all combinational.
  - DATA, read direction: txd_valid=mem_rvalid, mem_rready=txd_ready, txd_data=mem_rdata, all combinational.
  - DATA, beat counting: a beat completes when both valid and ready are 1; beat_cnt decrements on each completed beat.
  - DATA, exit: on the last beat, go to CALC if words_rem after update > 0, else go to DONE.
  - DATA, data gating: outside DATA state every data valid/ready output is 0, so no FIFO word is consumed or produced.
  - DONE: dma_ack=1 for exactly one cycle, then go to HOLD.
  - HOLD: 1 cycle, dma_req is ignored here because the producer clears it one cycle after ack. Then go to IDLE.
- **Error:** mem_err=1 in DATA sets dma_err and goes to DONE. The remaining beats of that burst are not driven, and dma_ack still pulses once.
- A change of dma_req or of the descriptor inputs mid-transfer is ignored; the descriptor latched in IDLE is used.
- Back-to-back requests: minimum 2 idle cycles (DONE, HOLD) between an ack and the next acceptance.
- Reset mid-transfer: immediate return to IDLE. No ack is issued; counters are cleared.

Decomposition:
- Package sata_dma_pkg holds:
  - the state enum {IDLE, CALC, CMD, DATA, DONE, HOLD};
  - the beats width constant (5);
  - the word-count width constant (14).
- Sub-module sata_dma_burst_calc computes and registers beats from cur_addr, words_rem and the parameters.

Test Plan:
- Write, addr 0x1000, len 64 → one burst (addr 0x1000, beats 16, rnw 0); 16 FIFO pops; one dma_ack pulse; dma_err=0.
- Read, addr 0x0FF8, len 40 → bursts (0x0FF8, 2), (0x1000, 8); 10 txd pushes; ack after the last push.
- Length 0 (dma_length=3) → no mem_cmd_valid; dma_ack 2 cycles after the request.
- Read with txd_ready and mem_cmd_ready toggled randomly, addr 0x2000, len 100 → 25 words in order; mem_addr/mem_beats stable while a command is stalled; single ack.
- Write, len 64, mem_err asserted at beat 5 → dma_err=1; ack pulses; exactly 5 pops; next request clears dma_err.
- Reset asserted mid-DATA on a 64-byte write → all outputs 0 asynchronously; no ack; a new request after release completes normally.
